// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and port ids shared by the ALU arbiter slice
package alu_pkg;
  localparam int CTRL_W = 6;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 6'b000000;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 6'b000001;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 6'b000010;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 6'b000100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 6'b000101;
  localparam logic [CTRL_W-1:0] ALU_OR   = 6'b000110;
  localparam logic [CTRL_W-1:0] ALU_AND  = 6'b000111;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 6'b001000;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 6'b001101;
  localparam logic [CTRL_W-1:0] ALU_BEQ  = 6'b010000;
  localparam logic [CTRL_W-1:0] ALU_BNE  = 6'b010001;
  localparam logic [CTRL_W-1:0] ALU_BGE  = 6'b010101;
  localparam logic [CTRL_W-1:0] ALU_JALR = 6'b111111;

  localparam logic P_EXE = 1'b0;
  localparam logic P_AUX = 1'b1;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: arithmetic/logic result plus compare flag
module alu #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = alu_pkg::CTRL_W
) (
  input  logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] alu_result,
  output logic              branch
);
  import alu_pkg::*;

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;
  assign shamt = operand_b[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    branch     = 1'b0;
    case (alu_control)
      ALU_ADD:  alu_result = operand_a + operand_b;
      ALU_SUB:  alu_result = operand_a - operand_b;
      ALU_SLL:  alu_result = operand_a << shamt;
      ALU_SRL:  alu_result = operand_a >> shamt;
      ALU_SRA:  alu_result = $signed(operand_a) >>> shamt;
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      ALU_XOR:  alu_result = operand_a ^ operand_b;
      ALU_OR:   alu_result = operand_a | operand_b;
      ALU_AND:  alu_result = operand_a & operand_b;
      ALU_BEQ:  branch = (operand_a == operand_b);
      ALU_BNE:  branch = (operand_a != operand_b);
      ALU_BGE:  branch = ($signed(operand_a) >= $signed(operand_b));
      ALU_JALR: alu_result = operand_a;
      default:  ;
    endcase
  end
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - 2-way grant, round-robin on ties or fixed priority to port 0
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  // prio names the port that wins the next tie; it flips away from each winner
  logic prio;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_EN && prio) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      prio <= 1'b0;
    else if (|grant)
      prio <= grant[0];
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between execute and aux ports via a 2-stage issue/result pipe
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = alu_pkg::CTRL_W,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_valid,
  output logic              p0_ready,
  input  logic [CTRL_W-1:0] p0_ctrl,
  input  logic              p0_branch_op,
  input  logic [DATA_W-1:0] p0_a,
  input  logic [DATA_W-1:0] p0_b,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_result,
  output logic              p0_branch,
  input  logic              p1_valid,
  output logic              p1_ready,
  input  logic [CTRL_W-1:0] p1_ctrl,
  input  logic              p1_branch_op,
  input  logic [DATA_W-1:0] p1_a,
  input  logic [DATA_W-1:0] p1_b,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_result,
  output logic              p1_branch
);
  import alu_pkg::*;

  logic [1:0]        elig, grant, drain;
  logic              issue_vld, issue_own, issue_bop;
  logic [CTRL_W-1:0] issue_ctrl;
  logic [DATA_W-1:0] issue_a, issue_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_branch;
  logic [1:0]        rsp_vld, rsp_br;
  logic [DATA_W-1:0] rsp_res [2];

  assign drain = {p1_rsp_valid & p1_rsp_ready, p0_rsp_valid & p0_rsp_ready};

  // One outstanding op per port: not in the issue stage, and its slot free or freeing now
  assign elig[0] = p0_valid & ~(issue_vld & (issue_own == P_EXE)) & (~p0_rsp_valid | drain[0]);
  assign elig[1] = p1_valid & ~(issue_vld & (issue_own == P_AUX)) & (~p1_rsp_valid | drain[1]);

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clock (clock),
    .reset (reset),
    .req   (elig),
    .grant (grant)
  );

  assign p0_ready = grant[0];
  assign p1_ready = grant[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      issue_vld  <= 1'b0;
      issue_own  <= P_EXE;
      issue_bop  <= 1'b0;
      issue_ctrl <= '0;
      issue_a    <= '0;
      issue_b    <= '0;
    end else begin
      issue_vld <= |grant;
      if (grant[1]) begin
        issue_own  <= P_AUX;
        issue_bop  <= p1_branch_op;
        issue_ctrl <= p1_ctrl;
        issue_a    <= p1_a;
        issue_b    <= p1_b;
      end else if (grant[0]) begin
        issue_own  <= P_EXE;
        issue_bop  <= p0_branch_op;
        issue_ctrl <= p0_ctrl;
        issue_a    <= p0_a;
        issue_b    <= p0_b;
      end
    end
  end

  alu #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_alu (
    .alu_control (issue_ctrl),
    .operand_a   (issue_a),
    .operand_b   (issue_b),
    .alu_result  (alu_result),
    .branch      (alu_branch)
  );

  // A retiring op refills its slot even when that slot drains on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_vld    <= 2'b00;
      rsp_br     <= 2'b00;
      rsp_res[0] <= '0;
      rsp_res[1] <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (issue_vld && (issue_own == 1'(n))) begin
          rsp_vld[n] <= 1'b1;
          rsp_res[n] <= alu_result;
          rsp_br[n]  <= alu_branch & issue_bop;
        end else if (drain[n]) begin
          rsp_vld[n] <= 1'b0;
        end
      end
    end
  end

  assign p0_rsp_valid = rsp_vld[0];
  assign p1_rsp_valid = rsp_vld[1];
  assign p0_result    = rsp_res[0];
  assign p1_result    = rsp_res[1];
  assign p0_branch    = rsp_br[0];
  assign p1_branch    = rsp_br[1];
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed checks of the shared-ALU arbiter (round-robin and fixed-priority builds)
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p0_valid, p0_branch_op, p0_rsp_ready;
  logic        p1_valid, p1_branch_op, p1_rsp_ready;
  logic [5:0]  p0_ctrl, p1_ctrl;
  logic [31:0] p0_a, p0_b, p1_a, p1_b;

  logic        p0_ready, p0_rsp_valid, p0_branch, p1_ready, p1_rsp_valid, p1_branch;
  logic [31:0] p0_result, p1_result;
  logic        f_p0_ready, f_p0_rsp_valid, f_p0_branch, f_p1_ready, f_p1_rsp_valid, f_p1_branch;
  logic [31:0] f_p0_result, f_p1_result;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(6), .RR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_ctrl(p0_ctrl), .p0_branch_op(p0_branch_op),
    .p0_a(p0_a), .p0_b(p0_b), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_result(p0_result), .p0_branch(p0_branch),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_ctrl(p1_ctrl), .p1_branch_op(p1_branch_op),
    .p1_a(p1_a), .p1_b(p1_b), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_result(p1_result), .p1_branch(p1_branch)
  );

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(6), .RR_EN(1'b0)) dut_fp (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(f_p0_ready), .p0_ctrl(p0_ctrl), .p0_branch_op(p0_branch_op),
    .p0_a(p0_a), .p0_b(p0_b), .p0_rsp_valid(f_p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_result(f_p0_result), .p0_branch(f_p0_branch),
    .p1_valid(p1_valid), .p1_ready(f_p1_ready), .p1_ctrl(p1_ctrl), .p1_branch_op(p1_branch_op),
    .p1_a(p1_a), .p1_b(p1_b), .p1_rsp_valid(f_p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_result(f_p1_result), .p1_branch(f_p1_branch)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic idle_inputs;
    p0_valid = 1'b0; p0_ctrl = ALU_ADD; p0_branch_op = 1'b0; p0_a = 0; p0_b = 0;
    p1_valid = 1'b0; p1_ctrl = ALU_ADD; p1_branch_op = 1'b0; p1_a = 0; p1_b = 0;
  endtask

  task automatic set_p0(input logic [5:0] c, input logic bop, input logic [31:0] a, input logic [31:0] b);
    p0_valid = 1'b1; p0_ctrl = c; p0_branch_op = bop; p0_a = a; p0_b = b;
  endtask

  task automatic set_p1(input logic [5:0] c, input logic bop, input logic [31:0] a, input logic [31:0] b);
    p1_valid = 1'b1; p1_ctrl = c; p1_branch_op = bop; p1_a = a; p1_b = b;
  endtask

  initial begin
    idle_inputs();
    p0_rsp_ready = 1'b0;
    p1_rsp_ready = 1'b0;
    repeat (2) tick();
    chk("rst_p0_rsp_valid", 32'(p0_rsp_valid), 0);
    chk("rst_p1_rsp_valid", 32'(p1_rsp_valid), 0);
    chk("rst_p0_result", p0_result, 0);
    chk("rst_p1_branch", 32'(p1_branch), 0);
    reset = 1'b1;

    // single ADD on port 0
    set_p0(ALU_ADD, 1'b0, 4, 5); #1;
    chk("t1_p0_ready", 32'(p0_ready), 1);
    chk("t1_p1_ready", 32'(p1_ready), 0);
    tick(); p0_valid = 1'b0; #1;
    chk("t1_rsp_early", 32'(p0_rsp_valid), 0);
    tick(); #1;
    chk("t1_rsp_valid", 32'(p0_rsp_valid), 1);
    chk("t1_result", p0_result, 9);
    chk("t1_branch", 32'(p0_branch), 0);
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    tick(); #1;
    chk("t1_drained", 32'(p0_rsp_valid), 0);

    // both ports every cycle; last winner was port 0, so port 1 leads
    set_p0(ALU_SUB, 1'b0, 9, 6);
    set_p1(ALU_SLL, 1'b0, 4, 2);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t2_p0_ready", 32'(p0_ready), 32'(i % 2 == 1));
      chk("t2_p1_ready", 32'(p1_ready), 32'(i % 2 == 0));
      if (i >= 2) begin
        chk("t2_p0_rsp_valid", 32'(p0_rsp_valid), 32'(i % 2 == 1));
        chk("t2_p1_rsp_valid", 32'(p1_rsp_valid), 32'(i % 2 == 0));
        if (i % 2 == 0) chk("t2_p1_result", p1_result, 16);
        else            chk("t2_p0_result", p0_result, 3);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // backpressure on port 1 while port 0 keeps flowing
    p1_rsp_ready = 1'b0;
    set_p1(ALU_BEQ, 1'b1, 32'hffff_ffff, 32'hffff_ffff); #1;
    chk("t3_p1_ready", 32'(p1_ready), 1);
    tick();
    set_p0(ALU_ADD, 1'b0, 1, 2); #1;
    chk("t3_p1_blocked_issue", 32'(p1_ready), 0);
    chk("t3_p0_ready", 32'(p0_ready), 1);
    tick();
    for (int i = 2; i < 7; i++) begin
      #1;
      chk("t3_p1_rsp_held", 32'(p1_rsp_valid), 1);
      chk("t3_p1_branch", 32'(p1_branch), 1);
      chk("t3_p1_blocked", 32'(p1_ready), 0);
      chk("t3_p0_served", 32'(p0_ready), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("t3_p0_result", p0_result, 3);
      tick();
    end
    idle_inputs();
    p1_rsp_ready = 1'b1; #1;
    chk("t3_release_valid", 32'(p1_rsp_valid), 1);
    tick(); #1;
    chk("t3_drained", 32'(p1_rsp_valid), 0);
    repeat (2) tick();

    // back-to-back ops on port 0 with the consumer always ready
    set_p0(ALU_BGE, 1'b1, 32, 31); #1;
    chk("t4_ready_a", 32'(p0_ready), 1);
    tick();
    set_p0(ALU_JALR, 1'b0, 32, 0); #1;
    chk("t4_ready_busy", 32'(p0_ready), 0);
    tick(); #1;
    chk("t4_rsp_a_valid", 32'(p0_rsp_valid), 1);
    chk("t4_rsp_a_branch", 32'(p0_branch), 1);
    chk("t4_ready_b", 32'(p0_ready), 1);
    tick(); p0_valid = 1'b0; #1;
    chk("t4_gap", 32'(p0_rsp_valid), 0);
    tick(); #1;
    chk("t4_rsp_b_valid", 32'(p0_rsp_valid), 1);
    chk("t4_rsp_b_result", p0_result, 32);
    chk("t4_rsp_b_branch", 32'(p0_branch), 0);
    tick(); #1;
    chk("t4_done", 32'(p0_rsp_valid), 0);
    tick();

    // fixed-priority build under continuous contention
    set_p0(ALU_ADD, 1'b0, 1, 1);
    set_p1(ALU_XOR, 1'b0, 6, 3);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t5_f_p0_ready", 32'(f_p0_ready), 32'(i % 2 == 0));
      chk("t5_f_p1_ready", 32'(f_p1_ready), 32'(i % 2 == 1));
      if (i >= 2 && i % 2 == 0) chk("t5_f_p0_result", f_p0_result, 2);
      if (i >= 2 && i % 2 == 1) chk("t5_f_p1_result", f_p1_result, 5);
      tick();
    end
    idle_inputs();
    repeat (3) tick();
    set_p0(ALU_ADD, 1'b0, 1, 1); #1;
    chk("t5_solo_f", 32'(f_p0_ready), 1);
    chk("t5_solo_rr", 32'(p0_ready), 1);
    tick(); p0_valid = 1'b0;
    tick();
    set_p0(ALU_ADD, 1'b0, 1, 1);
    set_p1(ALU_ADD, 1'b0, 2, 2); #1;
    chk("t5_tie_f_p0", 32'(f_p0_ready), 1);
    chk("t5_tie_f_p1", 32'(f_p1_ready), 0);
    chk("t5_tie_rr_p1", 32'(p1_ready), 1);
    chk("t5_tie_rr_p0", 32'(p0_ready), 0);
    tick(); idle_inputs();
    repeat (3) tick();

    // reset with one response parked and one op in the issue stage
    p0_rsp_ready = 1'b0; p1_rsp_ready = 1'b0;
    set_p1(ALU_ADD, 1'b0, 2, 2); #1;
    chk("t6_p1_ready", 32'(p1_ready), 1);
    tick();
    p1_valid = 1'b0;
    set_p0(ALU_ADD, 1'b0, 3, 3); #1;
    chk("t6_p0_ready", 32'(p0_ready), 1);
    tick(); idle_inputs(); #1;
    chk("t6_pre_p1_rsp", 32'(p1_rsp_valid), 1);
    reset = 1'b0; #1;
    chk("t6_rst_p0_rsp", 32'(p0_rsp_valid), 0);
    chk("t6_rst_p1_rsp", 32'(p1_rsp_valid), 0);
    chk("t6_rst_p1_result", p1_result, 0);
    chk("t6_rst_f_p1_rsp", 32'(f_p1_rsp_valid), 0);
    tick(); reset = 1'b1; #1;
    chk("t6_no_stale_rsp", 32'(p0_rsp_valid), 0);
    tick(); #1;
    chk("t6_no_late_rsp", 32'(p0_rsp_valid), 0);
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    set_p0(ALU_ADD, 1'b0, 1, 1);
    set_p1(ALU_ADD, 1'b0, 1, 1); #1;
    chk("t6_tie_p0", 32'(p0_ready), 1);
    chk("t6_tie_p1", 32'(p1_ready), 0);
    tick(); idle_inputs();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
